// File: rtl/pll_lock_monitor.sv
// PLL lock qualification: holds sys_reset until lock is stable for STABLE_CYCLES.
// Optional LOCK_LOSS_COUNT_EN adds a saturating 8-bit loss_count output.
module pll_lock_monitor #(
    parameter int unsigned STABLE_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       locked,
    output logic       sys_reset,
    output logic       ready,
    output logic       lock_lost
`ifdef LOCK_LOSS_COUNT_EN
    ,
    output logic [7:0] loss_count
`endif
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          sync_q1, locked_s;
    logic          lost_d;

    // locked is asynchronous to clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1  <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_q1  <= locked;
            locked_s <= sync_q1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            sys_reset <= 1'b1;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            sys_reset <= (state_d != RUN);
            ready     <= (state_d == RUN);
            lock_lost <= lost_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        lost_d  = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_d = '0;
                if (locked_s) begin
                    state_d = STABILIZE;
                end
            end
            STABILIZE: begin
                if (!locked_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt == LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!locked_s) begin
                    state_d = IDLE;
                    lost_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef LOCK_LOSS_COUNT_EN
    // Saturates rather than wraps so a flapping PLL stays visible
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loss_count <= 8'd0;
        end else if (lost_d && (loss_count != 8'hFF)) begin
            loss_count <= loss_count + 8'd1;
        end
    end
`endif

endmodule
